// File: rtl/des3_axil_slave_if.sv
// des3_axil_slave_if: AXI4-lite bus bundle between a master and the DES3 register slave.
interface des3_axil_slave_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/des3_axil_slave.sv
// des3_axil_slave: AXI4-lite register front end for a DES3 core; define DES3_AXIL_ERR_RESP_EN for SLVERR on bad accesses.
module des3_axil_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    des3_axil_slave_if.slave    bus,
    output logic [63:0]         key1_o,
    output logic [63:0]         key2_o,
    output logic [63:0]         key3_o,
    output logic [63:0]         des_in_o,
    output logic                decrypt_o,
    output logic                start_o,
    input  logic [63:0]         des_out_i,
    input  logic                out_valid_i
);
    if (DATA_WIDTH != 32) begin : g_dw_check
        $error("des3_axil_slave supports DATA_WIDTH = 32 only");
    end

    logic        aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic [3:0]  aw_idx_q, aw_idx_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [63:0] key1_q, key1_d, key2_q, key2_d, key3_q, key3_d;
    logic [63:0] in_q, in_d, out_q, out_d;
    logic        dec_q, dec_d, done_q, done_d, busy_q, busy_d, start_q, start_d;
    logic [3:0]  ridx;
    logic        commit, start_hit, werr, rerr;
    logic [31:0] rmux;
    logic        unused_addr;

    assign unused_addr = ^{bus.awaddr[ADDR_WIDTH-1:6], bus.awaddr[1:0],
                           bus.araddr[ADDR_WIDTH-1:6], bus.araddr[1:0]};

    assign ridx      = bus.araddr[5:2];
    assign commit    = aw_full_q && w_full_q;
    assign start_hit = commit && aw_idx_q == 4'd8 && w_strb_q[0] && w_data_q[0] && !busy_q;

`ifdef DES3_AXIL_ERR_RESP_EN
    assign werr = aw_idx_q >= 4'd10 || (aw_idx_q == 4'd8 && busy_q);
    assign rerr = ridx >= 4'd13;
`else
    assign werr = 1'b0;
    assign rerr = 1'b0;
`endif

    assign bus.awready = !rst_i && !aw_full_q && !bvalid_q;
    assign bus.wready  = !rst_i && !w_full_q && !bvalid_q;
    assign bus.arready = !rst_i && !rvalid_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;

    assign key1_o    = key1_q;
    assign key2_o    = key2_q;
    assign key3_o    = key3_q;
    assign des_in_o  = in_q;
    assign decrypt_o = dec_q;
    assign start_o   = start_q;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i+:8] = strb[i] ? data[8*i+:8] : old[8*i+:8];
        return r;
    endfunction

    // Read data mux over the register map, sampled at the AR handshake.
    always_comb begin
        case (ridx)
            4'd0:    rmux = key3_q[31:0];
            4'd1:    rmux = key3_q[63:32];
            4'd2:    rmux = key2_q[31:0];
            4'd3:    rmux = key2_q[63:32];
            4'd4:    rmux = key1_q[31:0];
            4'd5:    rmux = key1_q[63:32];
            4'd6:    rmux = in_q[31:0];
            4'd7:    rmux = in_q[63:32];
            4'd9:    rmux = {31'b0, dec_q};
            4'd10:   rmux = {31'b0, done_q};
            4'd11:   rmux = out_q[63:32];
            4'd12:   rmux = out_q[31:0];
            default: rmux = 32'b0;
        endcase
    end

    // Next state for the channel slots, register file and core handshake.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        key1_d    = key1_q;
        key2_d    = key2_q;
        key3_d    = key3_q;
        in_d      = in_q;
        out_d     = out_q;
        dec_d     = dec_q;
        done_d    = done_q;
        busy_d    = busy_q;
        start_d   = start_hit;
        if (bus.awvalid && bus.awready) begin
            aw_full_d = 1'b1;
            aw_idx_d  = bus.awaddr[5:2];
        end
        if (bus.wvalid && bus.wready) begin
            w_full_d = 1'b1;
            w_data_d = bus.wdata;
            w_strb_d = bus.wstrb;
        end
        if (bus.bvalid && bus.bready) bvalid_d = 1'b0;
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = werr ? 2'b10 : 2'b00;
            case (aw_idx_q)
                4'd0:    key3_d[31:0]  = merge(key3_q[31:0], w_data_q, w_strb_q);
                4'd1:    key3_d[63:32] = merge(key3_q[63:32], w_data_q, w_strb_q);
                4'd2:    key2_d[31:0]  = merge(key2_q[31:0], w_data_q, w_strb_q);
                4'd3:    key2_d[63:32] = merge(key2_q[63:32], w_data_q, w_strb_q);
                4'd4:    key1_d[31:0]  = merge(key1_q[31:0], w_data_q, w_strb_q);
                4'd5:    key1_d[63:32] = merge(key1_q[63:32], w_data_q, w_strb_q);
                4'd6:    in_d[31:0]    = merge(in_q[31:0], w_data_q, w_strb_q);
                4'd7:    in_d[63:32]   = merge(in_q[63:32], w_data_q, w_strb_q);
                4'd9:    dec_d         = w_strb_q[0] ? w_data_q[0] : dec_q;
                default: ;
            endcase
        end
        if (start_hit) begin
            busy_d = 1'b1;
            done_d = 1'b0;
        end
        if (out_valid_i && busy_q) begin
            out_d  = des_out_i;
            done_d = 1'b1;
            busy_d = 1'b0;
        end
        if (bus.rvalid && bus.rready) rvalid_d = 1'b0;
        if (bus.arvalid && bus.arready) begin
            rvalid_d = 1'b1;
            rdata_d  = rmux;
            rresp_d  = rerr ? 2'b10 : 2'b00;
        end
    end

    // State registers with synchronous reset clearing everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            key1_q    <= '0;
            key2_q    <= '0;
            key3_q    <= '0;
            in_q      <= '0;
            out_q     <= '0;
            dec_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            key1_q    <= key1_d;
            key2_q    <= key2_d;
            key3_q    <= key3_d;
            in_q      <= in_d;
            out_q     <= out_d;
            dec_q     <= dec_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
        end
    end
endmodule

// File: tb/tb_des3_axil_slave.sv
// tb_des3_axil_slave: directed AXI4-lite stimulus with response scoreboards for des3_axil_slave.
module tb_des3_axil_slave;
`ifdef DES3_AXIL_ERR_RESP_EN
    localparam logic [1:0] SLV = 2'b10;
`else
    localparam logic [1:0] SLV = 2'b00;
`endif
    localparam logic [1:0] OK = 2'b00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] key1, key2, key3, des_in;
    logic [63:0] des_out = '0;
    logic        decrypt, start;
    logic        out_valid = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          starts = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    des3_axil_slave_if bus ();

    des3_axil_slave dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .key1_o(key1), .key2_o(key2), .key3_o(key3), .des_in_o(des_in),
        .decrypt_o(decrypt), .start_o(start),
        .des_out_i(des_out), .out_valid_i(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: pops the expected response whenever a handshake is about to occur.
    always @(negedge clk) begin
        logic [1:0]  eb;
        logic [33:0] er;
        if (!rst && bus.bvalid && bus.bready) begin
            if (bq.size() == 0) chk("bresp_unexpected", 64'(bus.bresp), 64'h1_0000);
            else begin
                eb = bq.pop_front();
                chk("bresp", 64'(bus.bresp), 64'(eb));
            end
        end
        if (!rst && bus.rvalid && bus.rready) begin
            if (rq.size() == 0) chk("rdata_unexpected", 64'({bus.rresp, bus.rdata}), 64'h1_0000_0000_0000);
            else begin
                er = rq.pop_front();
                chk("rresp_rdata", 64'({bus.rresp, bus.rdata}), 64'(er));
            end
        end
        if (start) starts++;
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] er, input int aw_dly = 0, input int w_dly = 0,
                      input int hold = 0);
        bq.push_back(er);
        bus.bready = (hold == 0);
        fork
            begin
                repeat (aw_dly) tick();
                bus.awaddr  = a;
                bus.awvalid = 1'b1;
                for (int k = 0; k < 50 && !bus.awready; k++) tick();
                chk("awready_wait", 64'(bus.awready), 64'd1);
                tick();
                bus.awvalid = 1'b0;
            end
            begin
                repeat (w_dly) tick();
                bus.wdata  = d;
                bus.wstrb  = s;
                bus.wvalid = 1'b1;
                for (int k = 0; k < 50 && !bus.wready; k++) tick();
                chk("wready_wait", 64'(bus.wready), 64'd1);
                tick();
                bus.wvalid = 1'b0;
            end
        join
        for (int k = 0; k < 50 && !bus.bvalid; k++) tick();
        chk("bvalid_wait", 64'(bus.bvalid), 64'd1);
        for (int k = 0; k < hold; k++) begin
            chk("bvalid_held", 64'({bus.bvalid, bus.bresp}), 64'({1'b1, er}));
            tick();
        end
        bus.bready = 1'b1;
        tick();
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] er, input logic [31:0] ed);
        rq.push_back({er, ed});
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        for (int k = 0; k < 50 && !bus.arready; k++) tick();
        chk("arready_wait", 64'(bus.arready), 64'd1);
        tick();
        bus.arvalid = 1'b0;
        for (int k = 0; k < 50 && !bus.rvalid; k++) tick();
        chk("rvalid_wait", 64'(bus.rvalid), 64'd1);
        tick();
    endtask

    task automatic core(input logic [63:0] v);
        des_out   = v;
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_readies", 64'({bus.awready, bus.wready, bus.arready}), 64'd0);
        chk("rst_valids", 64'({bus.bvalid, bus.rvalid, start}), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_readies", 64'({bus.awready, bus.wready, bus.arready}), 64'h7);
        chk("post_rst_regs", 64'({bus.rdata, bus.bresp, bus.rresp, decrypt}), 64'd0);
        chk("post_rst_key1", key1, 64'd0);

        wr(32'h14, 32'h01234567, 4'hF, OK);
        wr(32'h10, 32'h89ABCDEF, 4'hF, OK);
        chk("key1", key1, 64'h0123456789ABCDEF);
        rd(32'h14, OK, 32'h01234567);

        wr(32'h08, 32'h11223344, 4'b0101, OK);
        wr(32'h10C, 32'hDEADBEEF, 4'hF, OK);
        chk("key2_strobe_highaddr", key2, 64'hDEADBEEF_00220044);

        fork
            wr(32'h0C, 32'hCAFEF00D, 4'hF, OK);
            begin
                tick();
                rd(32'h0C, OK, 32'hDEADBEEF);
            end
        join
        rd(32'h0C, OK, 32'hCAFEF00D);

        wr(32'h00, 32'hA5A5A5A5, 4'hF, OK, 0, 3, 0);
        wr(32'h04, 32'h5A5A5A5A, 4'hF, OK, 3, 0, 5);
        chk("key3", key3, 64'h5A5A5A5AA5A5A5A5);

        wr(32'h1C, 32'h736F6D65, 4'hF, OK);
        wr(32'h18, 32'h64617461, 4'hF, OK);
        chk("des_in", des_in, 64'h736F6D6564617461);
        wr(32'h20, 32'h1, 4'hF, OK);
        chk("start_pulses_1", 64'(starts), 64'd1);
        rd(32'h28, OK, 32'h0);
        repeat (20) tick();
        core(64'h3D124FE2198BA318);
        rd(32'h28, OK, 32'h1);
        rd(32'h2C, OK, 32'h3D124FE2);
        rd(32'h30, OK, 32'h198BA318);
        core(64'h1111111122222222);
        rd(32'h30, OK, 32'h198BA318);

        wr(32'h20, 32'h1, 4'hF, OK);
        wr(32'h20, 32'h1, 4'hF, SLV);
        wr(32'h20, 32'h1, 4'hF, SLV);
        chk("start_pulses_busy", 64'(starts), 64'd2);
        rd(32'h28, OK, 32'h0);
        core(64'hFEDCBA9876543210);
        rd(32'h28, OK, 32'h1);
        rd(32'h2C, OK, 32'hFEDCBA98);

        wr(32'h24, 32'h1, 4'b0000, OK);
        chk("decrypt_strb0", 64'(decrypt), 64'd0);
        wr(32'h24, 32'h1, 4'b0001, OK);
        chk("decrypt_set", 64'(decrypt), 64'd1);
        rd(32'h24, OK, 32'h1);

        wr(32'h34, 32'hFFFFFFFF, 4'hF, SLV);
        rd(32'h34, SLV, 32'h0);
        rd(32'h3C, SLV, 32'h0);
        rd(32'h20, OK, 32'h0);
        wr(32'h28, 32'h0, 4'hF, SLV);
        rd(32'h28, OK, 32'h1);

        wr(32'h20, 32'h1, 4'hF, OK);
        chk("start_pulses_3", 64'(starts), 64'd3);
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        core(64'h0F0F0F0F0F0F0F0F);
        tick();
        rd(32'h28, OK, 32'h0);
        rd(32'h2C, OK, 32'h0);
        rd(32'h30, OK, 32'h0);
        chk("rst_key1_decrypt", {key1[62:0], decrypt}, 64'd0);
        chk("scoreboard_drained", 64'(bq.size() + rq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/des3_axil_slave.md
DES3_AXIL_SLAVE -- requirements
Module: des3_axil_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AXI4-lite address width (byte address).
REQ-002 Parameter DATA_WIDTH, default 32, AXI4-lite data width (fixed at 32; other values unsupported).
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel.
REQ-006 wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
REQ-007 bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
REQ-008 araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address channel.
REQ-009 rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
REQ-010 key1_o/key2_o/key3_o  out  64 each  DES3 keys to core.
REQ-011 des_in_o  out  64  plaintext or ciphertext block to core.
REQ-012 decrypt_o  out  1  mode to core; 1 = decrypt.
REQ-013 start_o  out  1  one-cycle start pulse to core.
REQ-014 des_out_i/out_valid_i  in/in  64/1  core result and one-cycle result-valid strobe.

Function
REQ-015 Register map (offset = awaddr/araddr[5:0]; bits above 5 ignored): 0x00 key3[31:0], 0x04 key3[63:32], 0x08 key2[31:0], 0x0C key2[63:32], 0x10 key1[31:0], 0x14 key1[63:32], 0x18 in[31:0], 0x1C in[63:32], 0x20 START (W), 0x24 DECRYPT bit0 (R/W), 0x28 DONE bit0 (R), 0x2C out[63:32] (R), 0x30 out[31:0] (R); 0x34-0x3C unmapped.
REQ-016 Write path: AW and W captured independently (ready high while its holding slot empty and bvalid low); write commits in the cycle both slots are full; bvalid asserted the following cycle, held with bresp stable until bready.
REQ-017 No AW or W accepted while bvalid high; at most one write outstanding.
REQ-018 Key, input and DECRYPT writes honor wstrb per byte lane; wstrb=0 writes nothing but still returns a response.
REQ-019 A committed write to START with wstrb[0]=1 and wdata[0]=1 while idle: start_o high for exactly one cycle, the cycle after commit; DONE cleared and busy set the same cycle.
REQ-020 START write while busy: no pulse, no state change.
REQ-021 out_valid_i while busy: des_out_i captured into out register, DONE set, busy cleared next cycle; out_valid_i while idle ignored.
REQ-022 Read path: arready high when rvalid low; rvalid asserted cycle after AR handshake, rdata/rresp held until rready; unmapped and START reads return 0.
REQ-023 Read and write channels independent; read committing in the same cycle as a write to the same register returns the pre-write value.
REQ-024 key/in/decrypt outputs reflect register contents combinationally from the registers.

Reset
REQ-025 On rst_i: all registers, DONE, busy, start_o, bvalid, rvalid, rdata, bresp, rresp = 0; awready, wready, arready = 0 during reset, 1 the cycle after release.
REQ-026 Reset mid-operation aborts the pending transaction; a later out_valid_i is ignored (idle).

Configuration
REQ-027 Macro DES3_AXIL_ERR_RESP_EN defined: write to unmapped or read-only offset, or START while busy, returns bresp=SLVERR (2'b10); read of unmapped offset returns rresp=SLVERR, rdata=0.
REQ-028 Macro undefined: all responses OKAY (2'b00); such accesses silently ignored.

Verification
REQ-029 Write key1=0123456789ABCDEF to 0x14/0x10 -> key1_o=64'h0123456789ABCDEF, bresp=OKAY each.
REQ-030 Write in=736F6D6564617461, START=1; model core returns 3D124FE2198BA318 after 20 cycles -> start_o one pulse, DONE polls 0 then 1, 0x2C=3D124FE2, 0x30=198BA318.
REQ-031 AW presented 3 cycles before W, then W before AW with bready held low 5 cycles -> single commit each, bvalid held until bready.
REQ-032 START written twice while busy -> exactly one start_o pulse; bresp=SLVERR with DES3_AXIL_ERR_RESP_EN, OKAY without.
REQ-033 Write DECRYPT with wstrb=4'b0000 then 4'b0001 data 1 -> decrypt_o stays 0 then becomes 1.
REQ-034 rst_i asserted during busy, then out_valid_i -> DONE remains 0, out registers read 0.
